training_sequencer: RTL and testbench



---
 rtl/training_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_training_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/training_sequencer.sv
// Multi-lane link-training sequence generator: alternating 1/0 preamble then optional sync word.
// Build option: define TRAINING_SYNC_WORD_EN to include the SYNC phase; otherwise PREAMBLE ends the sequence.
module training_sequencer #(
  parameter int LANES      = 1,
  parameter int DIV_WIDTH  = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int SYNC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [LEN_WIDTH-1:0]  preamble_len,
  input  logic [SYNC_WIDTH-1:0] sync_word,
  input  logic [LANES-1:0]      lane_invert,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  tx_valid,
  output logic [LANES-1:0]      tx_data,
  output logic [1:0]            phase
);

  localparam int SYNC_CNT_W = $clog2(SYNC_WIDTH + 1);
  localparam int IDX_W      = (LEN_WIDTH > SYNC_CNT_W) ? LEN_WIDTH : SYNC_CNT_W;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE = IDX_W'(1);

  // Encoding doubles as the phase output value.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SYNC     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LANES-1:0]      inv_q, inv_d;
  logic                  done_d, aborted_d, pat;
  logic                  bit_end, pre_last;

`ifdef TRAINING_SYNC_WORD_EN
  // Shift register: the bit on air is always the MSB.
  logic [SYNC_WIDTH-1:0] sync_q, sync_d;
  logic                  sync_last;
  assign sync_last = (idx_q == IDX_W'(SYNC_WIDTH - 1));
`else
  logic unused_sync;
  assign unused_sync = ^sync_word;
`endif

  // div_q holds max(clk_div,1), so it is never zero while a sequence runs.
  assign bit_end  = (timer_q == div_q - DIV_ONE);
  assign pre_last = (idx_q == IDX_W'(len_q) - IDX_ONE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    div_d     = div_q;
    len_d     = len_q;
    inv_d     = inv_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
`ifdef TRAINING_SYNC_WORD_EN
    sync_d    = sync_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          div_d   = (clk_div == '0) ? DIV_ONE : clk_div;
          len_d   = preamble_len;
          inv_d   = lane_invert;
          timer_d = '0;
          idx_d   = '0;
`ifdef TRAINING_SYNC_WORD_EN
          sync_d  = sync_word;
          state_d = (preamble_len != '0) ? PREAMBLE : SYNC;
`else
          if (preamble_len != '0) state_d = PREAMBLE;
          else                    done_d  = 1'b1;
`endif
        end
      end

      PREAMBLE: begin
        if (abort) begin
          state_d   = IDLE;
          timer_d   = '0;
          idx_d     = '0;
          aborted_d = 1'b1;
        end else if (bit_end) begin
          timer_d = '0;
          if (pre_last) begin
            idx_d   = '0;
`ifdef TRAINING_SYNC_WORD_EN
            state_d = SYNC;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          timer_d = timer_q + DIV_ONE;
        end
      end

`ifdef TRAINING_SYNC_WORD_EN
      SYNC: begin
        if (abort) begin
          state_d   = IDLE;
          timer_d   = '0;
          idx_d     = '0;
          aborted_d = 1'b1;
        end else if (bit_end) begin
          timer_d = '0;
          if (sync_last) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + IDX_ONE;
            sync_d = sync_q << 1;
          end
        end else begin
          timer_d = timer_q + DIV_ONE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so the first bit appears one cycle after start.
    unique case (state_d)
      PREAMBLE: pat = ~idx_d[0];
`ifdef TRAINING_SYNC_WORD_EN
      SYNC:     pat = sync_d[SYNC_WIDTH-1];
`endif
      default:  pat = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      div_q    <= '0;
      len_q    <= '0;
      inv_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      phase    <= 2'd0;
`ifdef TRAINING_SYNC_WORD_EN
      sync_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      len_q    <= len_d;
      inv_q    <= inv_d;
      busy     <= (state_d != IDLE);
      done     <= done_d;
      aborted  <= aborted_d;
      tx_valid <= (state_d != IDLE);
      tx_data  <= (state_d == IDLE) ? '0 : ({LANES{pat}} ^ inv_d);
      phase    <= state_d;
`ifdef TRAINING_SYNC_WORD_EN
      sync_q   <= sync_d;
`endif
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Directed bench for training_sequencer (4 lanes, 4-bit sync word); expectations follow
// whichever TRAINING_SYNC_WORD_EN build is compiled.
module tb_training_sequencer;

  localparam int LANES      = 4;
  localparam int DIV_WIDTH  = 8;
  localparam int LEN_WIDTH  = 8;
  localparam int SYNC_WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DIV_WIDTH-1:0]  clk_div;
  logic [LEN_WIDTH-1:0]  preamble_len;
  logic [SYNC_WIDTH-1:0] sync_word;
  logic [LANES-1:0]      lane_invert;
  logic                  start, abort;
  logic                  busy, done, aborted, tx_valid;
  logic [LANES-1:0]      tx_data;
  logic [1:0]            phase;

  int total = 0;
  int bad   = 0;

  training_sequencer #(
    .LANES(LANES), .DIV_WIDTH(DIV_WIDTH), .LEN_WIDTH(LEN_WIDTH), .SYNC_WIDTH(SYNC_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .preamble_len(preamble_len),
    .sync_word(sync_word), .lane_invert(lane_invert), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .tx_valid(tx_valid),
    .tx_data(tx_data), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the start edge, i.e. at the first tx_valid cycle.
  task automatic do_start(input logic [7:0] div, input logic [7:0] len,
                          input logic [3:0] sw, input logic [3:0] inv);
    clk_div = div; preamble_len = len; sync_word = sw; lane_invert = inv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clk_div = '0; preamble_len = '0; sync_word = '0; lane_invert = '0;
    step(); step();
    rst = 1'b0;
    total++;
    if ({busy, done, aborted, tx_valid, tx_data, phase} !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b aborted=%b valid=%b data=%b phase=%0d, expected all 0",
               busy, done, aborted, tx_valid, tx_data, phase);
    end
  endtask

  // div=2, len=4: preamble 1,1,0,0,1,1,0,0; sync 0110 adds 0,0,1,1,1,1,0,0.
  task automatic test_basic();
    logic [3:0] ed[$];
    logic [1:0] ep[$];
    ed = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
    ep = '{1, 1, 1, 1, 1, 1, 1, 1};
`ifdef TRAINING_SYNC_WORD_EN
    ed = {ed, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
    ep = {ep, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
    do_start(8'd2, 8'd4, 4'b0110, 4'b0000);
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== ed[i] || phase !== ep[i]) begin
        bad++;
        $display("FAIL basic[%0d]: valid=%b busy=%b data=%b phase=%0d, expected 1 1 %b %0d",
                 i, tx_valid, busy, tx_data, phase, ed[i], ep[i]);
      end
      step();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== '0 || phase !== 2'd0) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b valid=%b data=%b phase=%0d, expected 1 0 0 0000 0",
               done, busy, tx_valid, tx_data, phase);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: done=%b, expected 0", done);
    end
  endtask

  // div=1, len=2, sync 1011: 1,0 then 1,0,1,1 in the sync phase.
  task automatic test_sync();
    logic [3:0] ed[$];
    logic [1:0] ep[$];
    ed = '{4'hF, 4'h0};
    ep = '{1, 1};
`ifdef TRAINING_SYNC_WORD_EN
    ed = {ed, 4'hF, 4'h0, 4'hF, 4'hF};
    ep = {ep, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
    do_start(8'd1, 8'd2, 4'b1011, 4'b0000);
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== ed[i] || phase !== ep[i]) begin
        bad++;
        $display("FAIL sync[%0d]: valid=%b data=%b phase=%0d, expected 1 %b %0d",
                 i, tx_valid, tx_data, phase, ed[i], ep[i]);
      end
      step();
    end
    total++;
    if (done !== 1'b1 || tx_valid !== 1'b0 || phase !== 2'd0) begin
      bad++;
      $display("FAIL sync_done: done=%b valid=%b phase=%0d, expected 1 0 0", done, tx_valid, phase);
    end
    step();
  endtask

  // clk_div=0 acts as 1; invert 0101 gives 1010 then 0101; all-zero sync word shows as 0101.
  task automatic test_invert();
    logic [3:0] ed[$];
    ed = '{4'b1010, 4'b0101};
`ifdef TRAINING_SYNC_WORD_EN
    ed = {ed, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
`endif
    do_start(8'd0, 8'd2, 4'b0000, 4'b0101);
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== ed[i]) begin
        bad++;
        $display("FAIL invert[%0d]: valid=%b data=%b, expected 1 %b", i, tx_valid, tx_data, ed[i]);
      end
      step();
    end
    total++;
    if (done !== 1'b1 || tx_data !== '0) begin
      bad++;
      $display("FAIL invert_done: done=%b data=%b, expected 1 0000", done, tx_data);
    end
    step();
  endtask

  // len=0: sync word straight away, or an immediate done with no valid data.
  task automatic test_zero_len();
    logic [3:0] ed[$];
    ed = {};
`ifdef TRAINING_SYNC_WORD_EN
    ed = '{4'hF, 4'hF, 4'h0, 4'h0};
`endif
    do_start(8'd1, 8'd0, 4'b1100, 4'b0000);
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== ed[i] || phase !== 2'd2) begin
        bad++;
        $display("FAIL zero_len[%0d]: valid=%b data=%b phase=%0d, expected 1 %b 2",
                 i, tx_valid, tx_data, phase, ed[i]);
      end
      step();
    end
    total++;
    if (done !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_done: done=%b valid=%b busy=%b, expected 1 0 0", done, tx_valid, busy);
    end
    step();
  endtask

  // len=8, div=3, abort raised during the 5th valid cycle (bit 1, value 0).
  task automatic test_abort();
    int seen_done;
    do_start(8'd3, 8'd8, 4'b1111, 4'b0000);
    step(); step(); step(); step();
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 4'h0 || phase !== 2'd1) begin
      bad++;
      $display("FAIL abort_pre: valid=%b data=%b phase=%0d, expected 1 0000 1", tx_valid, tx_data, phase);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (aborted !== 1'b1 || done !== 1'b0 || tx_valid !== 1'b0 || tx_data !== '0 ||
        busy !== 1'b0 || phase !== 2'd0) begin
      bad++;
      $display("FAIL abort: aborted=%b done=%b valid=%b data=%b busy=%b phase=%0d, expected 1 0 0 0000 0 0",
               aborted, done, tx_valid, tx_data, busy, phase);
    end
    seen_done = 0;
    step();
    total++;
    if (aborted !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse: aborted=%b, expected 0", aborted);
    end
    for (int i = 0; i < 40; i++) begin
      if (done || tx_valid) seen_done++;
      step();
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL abort_quiet: %0d cycles with done/valid, expected 0", seen_done);
    end
  endtask

  // start and abort together in IDLE: nothing happens, no aborted pulse.
  task automatic test_abort_start_idle();
    clk_div = 8'd1; preamble_len = 8'd3; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || aborted !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_start_idle: valid=%b busy=%b aborted=%b done=%b, expected 0 0 0 0",
               tx_valid, busy, aborted, done);
    end
    step();
  endtask

  // abort in the final cycle of the final bit beats completion.
  task automatic test_abort_last();
    int cycles;
`ifdef TRAINING_SYNC_WORD_EN
    cycles = (1 + SYNC_WIDTH) * 2;
`else
    cycles = 2;
`endif
    do_start(8'd2, 8'd1, 4'b0000, 4'b0000);
    for (int i = 1; i < cycles; i++) step();
    total++;
    if (tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL abort_last_pre: valid=%b, expected 1", tx_valid);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (aborted !== 1'b1 || done !== 1'b0 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_last: aborted=%b done=%b valid=%b, expected 1 0 0", aborted, done, tx_valid);
    end
    step();
    total++;
    if (done !== 1'b0 || aborted !== 1'b0) begin
      bad++;
      $display("FAIL abort_last_after: done=%b aborted=%b, expected 0 0", done, aborted);
    end
  endtask

  // Config changed and start re-asserted mid-run are ignored; a start in the done cycle is taken.
  task automatic test_capture_back_to_back();
    int pre, val, c, exp_val1, exp_val2;
`ifdef TRAINING_SYNC_WORD_EN
    exp_val1 = 4 + SYNC_WIDTH;
    exp_val2 = 9 + SYNC_WIDTH;
`else
    exp_val1 = 4;
    exp_val2 = 9;
`endif
    do_start(8'd1, 8'd4, 4'b1111, 4'b0000);
    pre = 0; val = 0; c = 0;
    while (c < 100 && done !== 1'b1) begin
      if (tx_valid) val++;
      if (phase == 2'd1) pre++;
      if (c == 1) begin
        preamble_len = 8'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      c++;
    end
    start = 1'b0;
    total++;
    if (done !== 1'b1 || pre != 4 || val != exp_val1) begin
      bad++;
      $display("FAIL capture: done=%b preamble_cycles=%0d valid_cycles=%0d, expected 1 4 %0d",
               done, pre, val, exp_val1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (tx_valid !== 1'b1 || busy !== 1'b1 || phase !== 2'd1 || tx_data !== 4'hF) begin
      bad++;
      $display("FAIL back_to_back: valid=%b busy=%b phase=%0d data=%b, expected 1 1 1 1111",
               tx_valid, busy, phase, tx_data);
    end
    val = 0; c = 0;
    while (c < 100 && done !== 1'b1) begin
      if (tx_valid) val++;
      step();
      c++;
    end
    total++;
    if (done !== 1'b1 || val != exp_val2) begin
      bad++;
      $display("FAIL back_to_back_len: done=%b valid_cycles=%0d, expected 1 %0d", done, val, exp_val2);
    end
    step();
  endtask

  // One-cycle rst in the middle of the sequence (SYNC when compiled in) clears everything silently.
  task automatic test_reset_mid();
    int pulses;
    logic [1:0] exp_ph;
`ifdef TRAINING_SYNC_WORD_EN
    do_start(8'd2, 8'd2, 4'b1010, 4'b0000);
    exp_ph = 2'd2;
`else
    do_start(8'd2, 8'd6, 4'b1010, 4'b0000);
    exp_ph = 2'd1;
`endif
    for (int i = 1; i < 6; i++) step();
    total++;
    if (tx_valid !== 1'b1 || phase !== exp_ph) begin
      bad++;
      $display("FAIL reset_mid_pre: valid=%b phase=%0d, expected 1 %0d", tx_valid, phase, exp_ph);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({busy, done, aborted, tx_valid, tx_data, phase} !== '0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b aborted=%b valid=%b data=%b phase=%0d, expected all 0",
               busy, done, aborted, tx_valid, tx_data, phase);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || aborted || tx_valid) pulses++;
      step();
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: %0d active cycles, expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sync();
    test_invert();
    test_zero_len();
    test_abort();
    test_abort_start_idle();
    test_abort_last();
    test_capture_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
